bcd_multi_decade_counter: RTL

//  Parametrised DIGITS-decade synchronous BCD counter: counts up or down, with

---
 rtl/bcd_multi_decade_counter_if.sv | 14 +
 rtl/bcd_multi_decade_counter.sv | 58 +++++
 2 files changed

// File: rtl/bcd_multi_decade_counter_if.sv
// bcd_multi_decade_counter_if: control, load and status signals of the BCD decade counter.
// The master drives the controls and the slave (the counter) returns count and flags.
interface bcd_multi_decade_counter_if #(parameter int DIGITS = 4);
  logic                  enable;
  logic                  up_dn;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   Q;
  logic                  done;
  logic                  wrap;
  modport master (output enable, up_dn, clear, load, load_val, input Q, done, wrap);
  modport slave  (input enable, up_dn, clear, load, load_val, output Q, done, wrap);
endinterface

// File: rtl/bcd_multi_decade_counter.sv
// bcd_multi_decade_counter: DIGITS-decade BCD up/down counter with clear, clamped load, terminal count and wrap pulse.
// Define BCD_COUNTER_SATURATE_EN to hold at the terminal count instead of wrapping (wrap then tied low).
module bcd_multi_decade_counter #(
  parameter int DIGITS = 4
) (
  input logic clk,
  input logic reset_n,
  bcd_multi_decade_counter_if.slave bus
);
  localparam int W = 4 * DIGITS;
  logic [W-1:0]      r_q;
  logic [W-1:0]      w_q_nxt;
  logic [W-1:0]      w_ld_clamped;
  logic [DIGITS-1:0] w_nine;
  logic [DIGITS-1:0] w_zero;
  logic [DIGITS-1:0] w_step;
  logic              w_done;
  logic              w_adv;
  assign w_step[0] = 1'b1;
  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_dig
      logic [3:0] w_d;
      logic [3:0] w_l;
      assign w_d = r_q[4*i +: 4];
      assign w_l = bus.load_val[4*i +: 4];
      assign w_nine[i] = w_d == 4'd9;
      assign w_zero[i] = w_d == 4'd0;
      assign w_ld_clamped[4*i +: 4] = w_l > 4'd9 ? 4'd9 : w_l;
      assign w_q_nxt[4*i +: 4] = !w_step[i] ? w_d :
                                 bus.up_dn ? (w_nine[i] ? 4'd0 : w_d + 4'd1) :
                                             (w_zero[i] ? 4'd9 : w_d - 4'd1);
      // a digit steps only when every lower digit is rolling over
      if (i < DIGITS - 1) begin : g_carry
        assign w_step[i+1] = w_step[i] & (bus.up_dn ? w_nine[i] : w_zero[i]);
      end
    end
  endgenerate
  assign w_done   = bus.up_dn ? &w_nine : &w_zero;
  assign bus.done = w_done;
  assign bus.Q    = r_q;
`ifdef BCD_COUNTER_SATURATE_EN
  assign w_adv    = bus.enable & ~w_done;
  assign bus.wrap = 1'b0;
`else
  logic r_wrap;
  assign w_adv    = bus.enable;
  assign bus.wrap = r_wrap;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_wrap <= 1'b0;
    else          r_wrap <= bus.enable & w_done & ~bus.clear & ~bus.load;
  end
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_q <= '0;
    else          r_q <= bus.clear ? '0 : bus.load ? w_ld_clamped : w_adv ? w_q_nxt : r_q;
  end
endmodule
